// File: rtl/vote_pkg.sv
// Types and constants shared by the vote input conditioner and the downstream voting_machine.
package vote_pkg;

  localparam int NUM_CAND = 4;
  localparam int IDX_W    = $clog2(NUM_CAND);

  typedef enum logic [2:0] {
    IDLE,
    ARMING,
    WAIT_RELEASE,
    REJECT,
    LOCKOUT
  } vote_state_t;

  typedef logic [NUM_CAND-1:0] vote_onehot_t;

  // Index of the set bit; only meaningful when exactly one bit is set.
  function automatic logic [IDX_W-1:0] onehot_index(input vote_onehot_t v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vote_sync.sv
// Single-bit multi-flop synchronizer for one raw, asynchronous button input.
module vote_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/vote_input_conditioner.sv
// Turns four raw candidate buttons into clean one-cycle vote pulses (hold qualify, reject, lockout).
// Optional feature: define VOTE_REJECT_CNT_EN to add a saturating reject_count output.
module vote_input_conditioner
  import vote_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 10,
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [3:0] vote,
  output logic       reject,
  output logic       busy
`ifdef VOTE_REJECT_CNT_EN
  ,
  output logic [7:0] reject_count
`endif
);

  localparam logic [7:0] HOLD_C = 8'(HOLD_CYCLES);
  localparam logic [7:0] LOCK_C = 8'(LOCKOUT_CYCLES);

  vote_onehot_t     raw_btn, sb, cap_mask;
  vote_state_t      state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  vote_onehot_t     vote_q, vote_d;
  logic             reject_q, reject_d;
  logic             busy_q, busy_d;

  assign raw_btn = {button4, button3, button2, button1};

  generate
    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_sync
      vote_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_btn[gi]),
        .q   (sb[gi])
      );
    end
  endgenerate

  always_comb begin
    cap_mask        = '0;
    cap_mask[idx_q] = 1'b1;
  end

  // One counter serves both the hold qualification and the lockout idle count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    vote_d   = '0;
    reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mode) begin
          if ($countones(sb) == 1) begin
            state_d = ARMING;
            idx_d   = onehot_index(sb);
            cnt_d   = 8'd1;
          end else if (sb != '0) begin
            state_d  = REJECT;
            reject_d = 1'b1;
          end
        end
      end
      ARMING: begin
        if (mode) begin
          state_d = WAIT_RELEASE;
          cnt_d   = 8'd0;
        end else if ((sb & ~cap_mask) != '0) begin
          state_d  = REJECT;
          reject_d = 1'b1;
          cnt_d    = 8'd0;
        end else if (cnt_q == HOLD_C) begin
          vote_d  = cap_mask;
          state_d = WAIT_RELEASE;
          cnt_d   = 8'd0;
        end else if (!sb[idx_q]) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_RELEASE, REJECT: begin
        if (sb == '0) begin
          state_d = LOCKOUT;
          cnt_d   = 8'd0;
        end
      end
      LOCKOUT: begin
        if (sb != '0) begin
          cnt_d = 8'd0;
        end else if (cnt_q + 8'd1 >= LOCK_C) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= '0;
      vote_q   <= '0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      vote_q   <= vote_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
    end
  end

  assign vote   = vote_q;
  assign reject = reject_q;
  assign busy   = busy_q;

`ifdef VOTE_REJECT_CNT_EN
  logic [7:0] rej_cnt_q, rej_cnt_d;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (reject_d && (rej_cnt_q != 8'hFF)) rej_cnt_d = rej_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rej_cnt_q <= 8'd0;
    else     rej_cnt_q <= rej_cnt_d;
  end

  assign reject_count = rej_cnt_q;
`endif

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Self-checking bench: directed episodes with hand-computed timings plus randomized button traffic,
// all compared every cycle against a behavioural model of the press/reject/lockout rules.
module tb_vote_input_conditioner;

  localparam int S = 2;
  localparam int H = 10;
  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic       button1 = 1'b0, button2 = 1'b0, button3 = 1'b0, button4 = 1'b0;
  logic [3:0] vote;
  logic       reject;
  logic       busy;
`ifdef VOTE_REJECT_CNT_EN
  logic [7:0] reject_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vote_input_conditioner #(
    .SYNC_STAGES    (S),
    .HOLD_CYCLES    (H),
    .LOCKOUT_CYCLES (L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .button1      (button1),
    .button2      (button2),
    .button3      (button3),
    .button4      (button4),
    .vote         (vote),
    .reject       (reject),
    .busy         (busy)
`ifdef VOTE_REJECT_CNT_EN
    ,
    .reject_count (reject_count)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_buttons(input logic [3:0] b);
    {button4, button3, button2, button1} = b;
  endtask

  // ---------------- behavioural model ----------------
  // A press is "held" (voted, aborted or rejected) until every button is up,
  // then needs a run of quiet cycles before a new press is accepted.
  typedef enum int {M_IDLE, M_ARM, M_HELD, M_LOCK} mphase_t;
  mphase_t    m_ph;
  int         m_cand, m_held, m_quiet;
  bit [3:0]   m_hist[$];
  bit [3:0]   exp_vote;
  bit         exp_reject, exp_busy;
  int         exp_rcnt;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_back(4'b0000);
    m_ph       = M_IDLE;
    m_cand     = 0;
    m_held     = 0;
    m_quiet    = 0;
    exp_vote   = '0;
    exp_reject = 1'b0;
    exp_busy   = 1'b0;
    exp_rcnt   = 0;
  endtask

  task automatic model_step(input bit [3:0] raw, input bit md);
    bit [3:0] sbm, cand_bit;
    int       n;
    sbm = m_hist.pop_front();
    m_hist.push_back(raw);
    n = $countones(sbm);
    exp_vote   = '0;
    exp_reject = 1'b0;
    case (m_ph)
      M_IDLE: begin
        if (!md && n == 1) begin
          m_ph = M_ARM;
          for (int i = 0; i < 4; i++) if (sbm[i]) m_cand = i;
          m_held = 1;
        end else if (!md && n > 1) begin
          m_ph = M_HELD;
          exp_reject = 1'b1;
        end
      end
      M_ARM: begin
        cand_bit = 4'b0001 << m_cand;
        if (md) m_ph = M_HELD;
        else if ((sbm & ~cand_bit) != 0) begin
          m_ph = M_HELD;
          exp_reject = 1'b1;
        end else if (m_held >= H) begin
          exp_vote = cand_bit;
          m_ph = M_HELD;
        end else if (sbm[m_cand] == 1'b0) m_ph = M_IDLE;
        else m_held++;
      end
      M_HELD: begin
        if (n == 0) begin
          m_ph = M_LOCK;
          m_quiet = 0;
        end
      end
      M_LOCK: begin
        if (n != 0) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet >= ((L > 0) ? L : 1)) m_ph = M_IDLE;
        end
      end
      default: m_ph = M_IDLE;
    endcase
    if (exp_reject && exp_rcnt < 255) exp_rcnt++;
    exp_busy = (m_ph != M_IDLE);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step({button4, button3, button2, button1}, mode);
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("vote", int'(vote), int'(exp_vote));
      chk("reject", int'(reject), int'(exp_reject));
      chk("busy", int'(busy), int'(exp_busy));
      chk("vote_exclusive", (($countones(vote) <= 1) && !((vote != 0) && reject)) ? 1 : 0, 1);
`ifdef VOTE_REJECT_CNT_EN
      chk("reject_count", int'(reject_count), exp_rcnt);
`endif
    end
  end

  // ---------------- directed episodes ----------------
  int ep_nvote, ep_vote_k, ep_vote_val, ep_nrej, ep_rej_k, ep_busy_hi, ep_busy_lo;

  function automatic logic pressed(input int j, input int hold, input int re_at, input int re_len);
    return (j < hold) || ((j >= re_at) && (j < re_at + re_len));
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Starts at posedge+2; edge E0 is the next rising edge. k counts edges E0..E(win-1).
  task automatic episode(input string tag, input logic [3:0] btn, input int hold,
                         input int re_at, input int re_len, input logic start_mode,
                         input int mode_at, input int win);
    ep_nvote = 0; ep_vote_k = -1; ep_vote_val = 0;
    ep_nrej = 0;  ep_rej_k = -1;  ep_busy_hi = -1; ep_busy_lo = -1;
    mode = start_mode;
    set_buttons(pressed(0, hold, re_at, re_len) ? btn : 4'b0000);
    for (int k = 0; k < win; k++) begin
      @(posedge clk);
      #2;
      set_buttons(pressed(k + 1, hold, re_at, re_len) ? btn : 4'b0000);
      if (k == mode_at) mode = 1'b1;
      @(negedge clk);
      if (vote != 0) begin
        ep_nvote++;
        if (ep_vote_k < 0) begin
          ep_vote_k   = k;
          ep_vote_val = int'(vote);
        end
      end
      if (reject) begin
        ep_nrej++;
        if (ep_rej_k < 0) ep_rej_k = k;
      end
      if (busy && ep_busy_hi < 0) ep_busy_hi = k;
      if (!busy && ep_busy_hi >= 0 && ep_busy_lo < 0) ep_busy_lo = k;
    end
    @(posedge clk);
    #2;
    mode = 1'b0;
    set_buttons(4'b0000);
    $display("episode %s: votes=%0d first_vote_k=%0d val=%0d rejects=%0d first_reject_k=%0d busy_hi_k=%0d busy_lo_k=%0d",
             tag, ep_nvote, ep_vote_k, ep_vote_val, ep_nrej, ep_rej_k, ep_busy_hi, ep_busy_lo);
  endtask

  int rem;
  int nv;
  logic [3:0] pat;

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_vote", int'(vote), 0);
    chk("reset_reject", int'(reject), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Single press held 15 cycles.
    do_reset();
    episode("b1_hold15", 4'b0001, 15, -1, 0, 1'b0, -1, 40);
    chk("b1_vote_k", ep_vote_k, 12);
    chk("b1_vote_val", ep_vote_val, 1);
    chk("b1_nvote", ep_nvote, 1);
    chk("b1_busy_hi", ep_busy_hi, 2);
    chk("b1_busy_lo", ep_busy_lo, 21);

    // Short press: no vote.
    do_reset();
    episode("b2_hold6", 4'b0010, 6, -1, 0, 1'b0, -1, 30);
    chk("b2_nvote", ep_nvote, 0);
    chk("b2_busy_lo", ep_busy_lo, 8);

    // Two buttons together.
    do_reset();
    episode("b23_multi", 4'b0110, 20, -1, 0, 1'b0, -1, 40);
    chk("b23_nrej", ep_nrej, 1);
    chk("b23_rej_k", ep_rej_k, 2);
    chk("b23_nvote", ep_nvote, 0);
    chk("b23_busy_lo", ep_busy_lo, 26);
`ifdef VOTE_REJECT_CNT_EN
    chk("b23_reject_count", int'(reject_count), 1);
`endif

    // Display mode for the whole press.
    do_reset();
    episode("b3_mode1", 4'b0100, 20, -1, 0, 1'b1, -1, 40);
    chk("b3m_nvote", ep_nvote, 0);
    chk("b3m_busy_hi", ep_busy_hi, -1);

    // Mode raised at the fifth arming cycle.
    do_reset();
    episode("b3_abort", 4'b0100, 20, -1, 0, 1'b0, 6, 40);
    chk("b3a_nvote", ep_nvote, 0);
    chk("b3a_busy_lo", ep_busy_lo, 26);

    // Long hold, then re-press during lockout.
    do_reset();
    episode("b4_long", 4'b1000, 200, 203, 30, 1'b0, -1, 260);
    chk("b4_nvote", ep_nvote, 1);
    chk("b4_vote_k", ep_vote_k, 12);
    chk("b4_vote_val", ep_vote_val, 8);
    chk("b4_busy_lo", ep_busy_lo, 238);
    episode("b4_new", 4'b1000, 15, -1, 0, 1'b0, -1, 40);
    chk("b4n_vote_k", ep_vote_k, 12);
    chk("b4n_nvote", ep_nvote, 1);

    // Reset in the middle of arming with the button still held.
    do_reset();
    set_buttons(4'b0001);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("rstmid_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_vote", int'(vote), 0);
    chk("rstmid_reject", int'(reject), 0);
    chk("rstmid_busy", int'(busy), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    episode("b1_after_rst", 4'b0001, 15, -1, 0, 1'b0, -1, 40);
    chk("rstmid_vote_k", ep_vote_k, 12);
    chk("rstmid_vote_val", ep_vote_val, 1);

    // Randomized traffic.
    do_reset();
    rem = 0;
    nv  = 0;
    pat = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      if (rst) rst = 1'b0;
      if (rem == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: pat = 4'b0000;
          4, 5, 6, 7: pat = 4'(4'b0001 << $urandom_range(0, 3));
          default:    pat = 4'($urandom_range(1, 15));
        endcase
        rem = $urandom_range(0, 24);
      end else begin
        rem--;
      end
      set_buttons(pat);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      @(negedge clk);
      if (vote != 0) nv++;
    end
    @(posedge clk);
    #2 rst = 1'b0;
    set_buttons(4'b0000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("random phase: %0d votes observed", nv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
